spi_cfg_controller: RTL



---
 rtl/spi_cfg_pkg.sv | 28 ++
 rtl/cfg_req_fifo.sv | 55 +++++
 rtl/spi_cfg_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared constants, register map and FSM state type for the SPI configuration
// write controller.
package spi_cfg_pkg;

  localparam int         SPI_FRAME_W   = 16;
  localparam logic       SPI_WRITE_BIT = 1'b1;
  localparam int         REQ_W         = SPI_FRAME_W - 1;

  localparam logic [6:0] REG_EN_OUT_LO = 7'd0;
  localparam logic [6:0] REG_EN_OUT_HI = 7'd1;
  localparam logic [6:0] REG_EN_PWM_LO = 7'd2;
  localparam logic [6:0] REG_EN_PWM_HI = 7'd3;
  localparam logic [6:0] REG_PWM_DUTY  = 7'd4;
  localparam logic [6:0] REG_ADDR_MAX  = REG_PWM_DUTY;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_e;

  function automatic logic addr_legal(input logic [6:0] addr);
    return addr <= REG_ADDR_MAX;
  endfunction

endpackage

// File: rtl/cfg_req_fifo.sv
// Request queue holding {addr, data} entries; an extra pointer bit separates
// full from empty. Next-cycle flags let the owner register its ready output.
module cfg_req_fifo
  import spi_cfg_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [REQ_W-1:0] wdata_i,
  output logic [REQ_W-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             full_next_o,
  output logic             empty_next_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
    $error("cfg_req_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [REQ_W-1:0] mem_q [FIFO_DEPTH];
  logic             push_ok, pop_ok;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign wr_d    = wr_q + {{AW{1'b0}}, push_ok};
  assign rd_d    = rd_q + {{AW{1'b0}}, pop_ok};

  assign full_o       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o      = (wr_q == rd_q);
  assign full_next_o  = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
  assign empty_next_o = (wr_d == rd_d);
  assign rdata_o      = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/spi_cfg_controller.sv
// SPI mode-0 write-only master: queues register writes and serialises each as a
// 16-bit {1, addr, data} frame, paced slowly for a synchronising peripheral.
module spi_cfg_controller
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CS_GAP     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  output logic       busy,
  output logic       tx_done,
  output logic       err_addr,
  output state_e     dbg_state
);

  if (CLK_DIV < 3) begin : g_bad_div
    $error("spi_cfg_controller: CLK_DIV must be >= 3");
  end
  if (CS_GAP < 2) begin : g_bad_gap
    $error("spi_cfg_controller: CS_GAP must be >= 2");
  end

  localparam int             CNT_MAX  = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int             CNT_W    = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [3:0]         bit_q, bit_d;
  logic [SPI_FRAME_W-1:0] shreg_q, shreg_d;
  logic               sclk_q, sclk_d, copi_q, copi_d, ncs_q, ncs_d;
  logic               tx_done_q, tx_done_d;
  logic               err_addr_q, busy_q, req_ready_q;
  logic               push, pop, addr_bad;
  logic               fifo_full, fifo_empty, full_nx, empty_nx;
  logic [REQ_W-1:0]   head;

  // A request transfers on a clk edge where req_valid && req_ready are both
  // high; req_ready is registered and only reflects FIFO space, never req_valid.
  assign push     = req_valid && req_ready_q && !fifo_full && addr_legal(req_addr);
  assign addr_bad = req_valid && req_ready_q && !addr_legal(req_addr);

  cfg_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .pop_i        (pop),
    .wdata_i      ({req_addr, req_data}),
    .rdata_o      (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .full_next_o  (full_nx),
    .empty_next_o (empty_nx)
  );

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    sclk_d    = sclk_q;
    copi_d    = copi_q;
    ncs_d     = ncs_q;
    tx_done_d = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = {SPI_WRITE_BIT, head};
          copi_d  = SPI_WRITE_BIT;
          ncs_d   = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          bit_d   = 4'd15;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: the peripheral has sampled, present the next bit.
            sclk_d = 1'b0;
            if (bit_q == 4'd0) begin
              state_d = HOLD;
            end else begin
              bit_d   = bit_q - 4'd1;
              shreg_d = {shreg_q[SPI_FRAME_W-2:0], shreg_q[SPI_FRAME_W-1]};
              copi_d  = shreg_q[SPI_FRAME_W-2];
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      HOLD: begin
        if (div_q == DIV_LAST) begin
          div_d     = '0;
          ncs_d     = 1'b1;
          copi_d    = 1'b0;
          tx_done_d = 1'b1;
          state_d   = GAP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (div_q == GAP_LAST) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      sclk_q      <= 1'b0;
      copi_q      <= 1'b0;
      ncs_q       <= 1'b1;
      tx_done_q   <= 1'b0;
      err_addr_q  <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      sclk_q      <= sclk_d;
      copi_q      <= copi_d;
      ncs_q       <= ncs_d;
      tx_done_q   <= tx_done_d;
      err_addr_q  <= addr_bad;
      busy_q      <= (state_d != IDLE) || !empty_nx;
      req_ready_q <= !full_nx;
    end
  end

  assign req_ready = req_ready_q;
  assign sclk      = sclk_q;
  assign copi      = copi_q;
  assign ncs       = ncs_q;
  assign busy      = busy_q;
  assign tx_done   = tx_done_q;
  assign err_addr  = err_addr_q;
  assign dbg_state = state_q;

endmodule
